// File: rtl/femto_bus_pkg.sv
// Shared definitions for the iomem-to-Wishbone bridge: FSM encoding, default
// timeout read data and a width helper for the wait counter.
package femto_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } bridge_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h00BADADD;

  // Bits needed to hold value-1; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Wishbone wait counter: clears outside a bus cycle, counts unacked cycles and
// saturates at the terminal count TIMEOUT-1.
module wb_timeout_ctr
  import femto_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = clog2_w(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/iomem_wb_bridge.sv
// Bridges picorv32 iomem requests in one address window onto a single-beat
// Wishbone master, aborting with ERR_DATA if the slave never acknowledges.
module iomem_wb_bridge
  import femto_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_HI  = 8'h04,
  parameter int unsigned WB_ADR_W = 8,
  parameter int unsigned WB_DAT_W = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [WB_ADR_W-1:0]   wb_adr_o,
  output logic [WB_DAT_W-1:0]   wb_dat_o,
  output logic [WB_DAT_W/8-1:0] wb_sel_o,
  input  logic [WB_DAT_W-1:0]   wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  timeout_o
);

  localparam int unsigned SEL_W = WB_DAT_W / 8;

  if (!(WB_DAT_W == 8 || WB_DAT_W == 32) || TIMEOUT < 2 || TIMEOUT > 65535)
  begin : g_param_check
    $error("iomem_wb_bridge: WB_DAT_W must be 8 or 32 and TIMEOUT within 2..65535");
  end

  bridge_state_e state_q, state_d;

  logic                req_hit;
  logic                cnt_tc;
  logic                ack_hit;
  logic                to_hit;
  logic                we_load;
  logic [SEL_W-1:0]    sel_load;
  logic [WB_DAT_W-1:0] dat_load;

  logic                we_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [SEL_W-1:0]    sel_q;
  logic [31:0]         rdata_q;
  logic                timeout_q;

  logic unused_inputs;
  assign unused_inputs = ^{iomem_addr, iomem_wdata, iomem_wstrb};

  if (WB_DAT_W == 32) begin : g_w32
    assign we_load  = |iomem_wstrb;
    assign sel_load = SEL_W'((|iomem_wstrb) ? iomem_wstrb : 4'hF);
  end else begin : g_w8
    assign we_load  = iomem_wstrb[0];
    assign sel_load = SEL_W'(1'b1);
  end
  assign dat_load = iomem_wdata[WB_DAT_W-1:0];

  assign req_hit = iomem_valid && (iomem_addr[31:24] == BASE_HI) && !iomem_ready;
  assign ack_hit = (state_q == StBus) && wb_ack_i;
  // Ack wins over a simultaneous terminal count.
  assign to_hit  = (state_q == StBus) && !wb_ack_i && cnt_tc;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_q != StBus),
    .en     ((state_q == StBus) && !wb_ack_i),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_hit) state_d = StBus;
      StBus:   if (ack_hit || to_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_cyc_o    = (state_q == StBus);
    wb_stb_o    = (state_q == StBus);
    iomem_ready = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && req_hit) begin
        we_q  <= we_load;
        adr_q <= iomem_addr[WB_ADR_W+1:2];
        dat_q <= dat_load;
        sel_q <= sel_load;
      end
      if (ack_hit) begin
        rdata_q <= 32'(wb_dat_i);
      end else if (to_hit) begin
        rdata_q <= ERR_DATA;
      end
      timeout_q <= to_hit;
    end
  end

  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign iomem_rdata = rdata_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_iomem_wb_bridge.sv
// Bench for iomem_wb_bridge: an 8-bit and a 32-bit instance, both TIMEOUT=4,
// with expected responses queued at request time and popped on iomem_ready.
module tb_iomem_wb_bridge;

  typedef struct packed {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;

  logic        v8 = 1'b0, ack8 = 1'b0;
  logic [7:0]  dati8 = '0;
  logic        rdy8, cyc8, stb8, we8, sel8, to8;
  logic [31:0] rd8;
  logic [7:0]  adr8, dato8;

  logic        v32 = 1'b0, ack32 = 1'b0;
  logic [31:0] dati32 = '0;
  logic        rdy32, cyc32, stb32, we32, to32;
  logic [31:0] rd32, dato32;
  logic [7:0]  adr32;
  logic [3:0]  sel32;

  exp_t exp8_q[$];
  exp_t exp32_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  iomem_wb_bridge #(.WB_DAT_W(8), .TIMEOUT(4)) dut8 (
    .clk(clk), .resetn(resetn), .iomem_valid(v8), .iomem_ready(rdy8),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rd8), .wb_cyc_o(cyc8), .wb_stb_o(stb8), .wb_we_o(we8), .wb_adr_o(adr8),
    .wb_dat_o(dato8), .wb_sel_o(sel8), .wb_dat_i(dati8), .wb_ack_i(ack8), .timeout_o(to8)
  );

  iomem_wb_bridge #(.WB_DAT_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .resetn(resetn), .iomem_valid(v32), .iomem_ready(rdy32),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rd32), .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_we_o(we32), .wb_adr_o(adr32),
    .wb_dat_o(dato32), .wb_sel_o(sel32), .wb_dat_i(dati32), .wb_ack_i(ack32), .timeout_o(to32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; v8 = 1'b0; v32 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({cyc8, stb8, rdy8, to8, we8, sel8} !== 6'b0)
      $display("FAIL reset_ctl8: got %b want 000000", {cyc8, stb8, rdy8, to8, we8, sel8});
    else n_pass++;
    n_checks++;
    if ({rd8, adr8, dato8} !== 48'h0)
      $display("FAIL reset_data8: got %h want 0", {rd8, adr8, dato8});
    else n_pass++;
    n_checks++;
    if ({cyc32, stb32, rdy32, to32, we32, sel32} !== 9'b0)
      $display("FAIL reset_ctl32: got %b want 0", {cyc32, stb32, rdy32, to32, we32, sel32});
    else n_pass++;
    n_checks++;
    if ({rd32, dato32, adr32} !== 72'h0)
      $display("FAIL reset_data32: got %h want 0", {rd32, dato32, adr32});
    else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read8();
    exp_t e;
    exp8_q.push_back(exp_t'{rdata: 32'h0000005A, to: 1'b0});
    iomem_addr = 32'h0400_0010; iomem_wstrb = 4'h0; v8 = 1'b1;
    tick();
    n_checks++;
    if ({cyc8, stb8, we8, sel8} !== 4'b1101)
      $display("FAIL read8_bus: got %b want 1101", {cyc8, stb8, we8, sel8});
    else n_pass++;
    n_checks++;
    if (adr8 !== 8'h04) $display("FAIL read8_adr: got %h want 04", adr8);
    else n_pass++;
    ack8 = 1'b1; dati8 = 8'h5A;
    tick();
    ack8 = 1'b0;
    n_checks++;
    if (rdy8 !== 1'b1) $display("FAIL read8_ready: got %b want 1", rdy8);
    else n_pass++;
    n_checks++;
    if (exp8_q.size() == 0) $display("FAIL read8_sb: scoreboard empty");
    else begin
      e = exp8_q.pop_front();
      if ({rd8, to8} !== {e.rdata, e.to})
        $display("FAIL read8_rdata: got %h/%b want %h/%b", rd8, to8, e.rdata, e.to);
      else n_pass++;
    end
    v8 = 1'b0;
    tick();
    n_checks++;
    if ({rdy8, cyc8} !== 2'b00 || rd8 !== 32'h0000005A)
      $display("FAIL read8_hold: got rdy %b cyc %b rdata %h want 0 0 0000005a", rdy8, cyc8, rd8);
    else n_pass++;
  endtask

  task automatic test_write32();
    exp_t e;
    exp32_q.push_back(exp_t'{rdata: 32'hCAFE0001, to: 1'b0});
    iomem_addr = 32'h0400_0020; iomem_wstrb = 4'b0110; iomem_wdata = 32'h11223344; v32 = 1'b1;
    tick();
    n_checks++;
    if ({cyc32, stb32, we32} !== 3'b111) $display("FAIL write32_we: got %b want 111", {cyc32, stb32, we32});
    else n_pass++;
    n_checks++;
    if (sel32 !== 4'b0110) $display("FAIL write32_sel: got %b want 0110", sel32);
    else n_pass++;
    n_checks++;
    if ({dato32, adr32} !== {32'h11223344, 8'h08})
      $display("FAIL write32_dat_adr: got %h %h want 11223344 08", dato32, adr32);
    else n_pass++;
    ack32 = 1'b1; dati32 = 32'hCAFE0001;
    tick();
    ack32 = 1'b0; v32 = 1'b0;
    n_checks++;
    if (exp32_q.size() == 0) $display("FAIL write32_sb: scoreboard empty");
    else begin
      e = exp32_q.pop_front();
      if ({rdy32, rd32, to32} !== {1'b1, e.rdata, e.to})
        $display("FAIL write32_resp: got %b/%h/%b want 1/%h/%b", rdy32, rd32, to32, e.rdata, e.to);
      else n_pass++;
    end
    iomem_wstrb = 4'h0;
    tick();
  endtask

  task automatic do_read32(input logic [31:0] addr, input logic [31:0] data, input int waits);
    exp_t e;
    bit   got;
    exp32_q.push_back(exp_t'{rdata: data, to: 1'b0});
    iomem_addr = addr; iomem_wstrb = 4'h0; v32 = 1'b1;
    tick();
    n_checks++;
    if ({cyc32, we32, sel32, adr32} !== {1'b1, 1'b0, 4'hF, addr[9:2]})
      $display("FAIL read32_bus: got cyc %b we %b sel %h adr %h want 1 0 f %h",
               cyc32, we32, sel32, adr32, addr[9:2]);
    else n_pass++;
    dati32 = data;
    repeat (waits) tick();
    ack32 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      ack32 = 1'b0;
      if (rdy32) got = 1'b1;
    end
    v32 = 1'b0;
    n_checks++;
    if (!got) $display("FAIL read32_ready: got no ready within 8 cycles want ready");
    else if (exp32_q.size() == 0) $display("FAIL read32_sb: scoreboard empty");
    else begin
      e = exp32_q.pop_front();
      if ({rd32, to32} !== {e.rdata, e.to})
        $display("FAIL read32_rdata: got %h/%b want %h/%b", rd32, to32, e.rdata, e.to);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_read32(32'h0400_0100, 32'hDEADBEEF, 0);
    do_read32(32'h0400_0104, 32'h01234567, 2);
  endtask

  task automatic test_timeout();
    exp_t        e;
    int          stb_cycles, rdy_cnt, to_cnt;
    logic [31:0] rd_at;
    logic        to_at;
    rd_at = '0; to_at = 1'b0; rdy_cnt = 0; to_cnt = 0;
    exp8_q.push_back(exp_t'{rdata: 32'h00BADADD, to: 1'b1});
    iomem_addr = 32'h0400_0004; iomem_wstrb = 4'h0; v8 = 1'b1; ack8 = 1'b0;
    tick();
    stb_cycles = stb8 ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stb8) stb_cycles++;
      if (to8) to_cnt++;
      if (rdy8) begin
        rdy_cnt++;
        rd_at = rd8;
        to_at = to8;
        v8 = 1'b0;
      end
    end
    v8 = 1'b0;
    n_checks++;
    if (stb_cycles != 4) $display("FAIL timeout_stb_cycles: got %0d want 4", stb_cycles);
    else n_pass++;
    n_checks++;
    if (rdy_cnt != 1 || to_cnt != 1)
      $display("FAIL timeout_pulses: got ready %0d timeout %0d want 1 1", rdy_cnt, to_cnt);
    else n_pass++;
    n_checks++;
    if (exp8_q.size() == 0) $display("FAIL timeout_sb: scoreboard empty");
    else begin
      e = exp8_q.pop_front();
      if ({rd_at, to_at} !== {e.rdata, e.to})
        $display("FAIL timeout_rdata: got %h/%b want %h/%b", rd_at, to_at, e.rdata, e.to);
      else n_pass++;
    end
  endtask

  task automatic test_ack_on_terminal();
    exp_t e;
    exp8_q.push_back(exp_t'{rdata: 32'h000000C3, to: 1'b0});
    iomem_addr = 32'h0400_0008; iomem_wstrb = 4'h0; v8 = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++;
    if (cyc8 !== 1'b1) $display("FAIL term_still_bus: got %b want 1", cyc8);
    else n_pass++;
    ack8 = 1'b1; dati8 = 8'hC3;
    tick();
    ack8 = 1'b0; v8 = 1'b0;
    n_checks++;
    if (exp8_q.size() == 0) $display("FAIL term_sb: scoreboard empty");
    else begin
      e = exp8_q.pop_front();
      if ({rdy8, rd8, to8} !== {1'b1, e.rdata, e.to})
        $display("FAIL term_resp: got %b/%h/%b want 1/%h/%b", rdy8, rd8, to8, e.rdata, e.to);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({to8, rdy8} !== 2'b00) $display("FAIL term_no_late_timeout: got %b want 00", {to8, rdy8});
    else n_pass++;
  endtask

  task automatic test_ack_ignored();
    ack8 = 1'b1; dati8 = 8'hFF; v8 = 1'b0;
    repeat (3) tick();
    ack8 = 1'b0;
    n_checks++;
    if ({cyc8, rdy8, to8} !== 3'b000 || rd8 !== 32'h000000C3)
      $display("FAIL idle_ack: got ctl %b rdata %h want 000 000000c3", {cyc8, rdy8, to8}, rd8);
    else n_pass++;
  endtask

  task automatic test_nonmatch();
    bit seen;
    seen = 1'b0;
    iomem_addr = 32'h0100_0000; iomem_wstrb = 4'h0; v8 = 1'b1; v32 = 1'b1;
    repeat (6) begin
      tick();
      if (cyc8 || cyc32 || rdy8 || rdy32) seen = 1'b1;
    end
    v8 = 1'b0; v32 = 1'b0;
    n_checks++;
    if (seen !== 1'b0) $display("FAIL nonmatch: got activity %b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_in_bus();
    bit seen;
    seen = 1'b0;
    iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0; v8 = 1'b1;
    tick();
    n_checks++;
    if (cyc8 !== 1'b1) $display("FAIL rstbus_enter: got %b want 1", cyc8);
    else n_pass++;
    resetn = 1'b0; v8 = 1'b0;
    tick();
    n_checks++;
    if ({cyc8, stb8} !== 2'b00 || rd8 !== 32'h0)
      $display("FAIL rstbus_drop: got cyc %b stb %b rdata %h want 0 0 0", cyc8, stb8, rd8);
    else n_pass++;
    resetn = 1'b1;
    repeat (6) begin
      tick();
      if (rdy8 || to8 || cyc8) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rstbus_no_ready: got activity %b want 0", seen);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read8();
    test_write32();
    test_back_to_back();
    test_timeout();
    test_ack_on_terminal();
    test_ack_ignored();
    test_nonmatch();
    test_reset_in_bus();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
